// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// FSM state and owner encodings, default parameter values.
package unified_mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and memory bus signals of the unified memory arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              bus_err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_ack, d_stall,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_rdata, mem_ready,
    output bus_err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_ack, d_stall,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_rdata, mem_ready,
    input  bus_err
  );

endinterface

// File: rtl/unified_mem_arbiter_timeout.sv
// Memory timeout counter: counts while enabled, clears on clr.
// Ports: clk, rst_n, clr, en in; expire out at count LIMIT-1.
module mem_arb_timeout_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and data ports.
// Ports: clk, rst_n, bus (fetch/data/memory handshakes, bus_err).
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  owner_t            own_q, own_d;
  logic [3:0]        starve_q, starve_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [BE_W-1:0]   mbe_q, mbe_d;
  logic              iack_q, iack_d;
  logic              dack_q, dack_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              berr_q, berr_d;

  logic              busy;
  logic              gnt_i;
  logic              gnt_d;
  logic              tmo_en;
  logic              tmo_exp;
  logic              fin;
  logic [DATA_W-1:0] cap;

  assign busy   = (state_q == S_BUSY);
  assign tmo_en = busy & ~bus.mem_ready & ~tmo_exp;

  // Data wins unless fetch has waited STARVE_MAX grants.
  assign gnt_i = bus.if_req &
                 (~bus.d_req | (starve_q == SMAX));
  assign gnt_d = bus.d_req & ~gnt_i;

  mem_arb_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~busy),
    .en     (tmo_en),
    .expire (tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      own_q    <= OWN_I;
      starve_q <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      starve_q <= starve_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      berr_q   <= berr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    starve_d = starve_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    irdata_d = '0;
    drdata_d = '0;
    berr_d   = berr_q;
    fin      = 1'b0;
    cap      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.if_req) starve_d = '0;
        unique case (1'b1)
          gnt_i: begin
            own_d    = OWN_I;
            mwe_d    = 1'b0;
            maddr_d  = bus.if_addr;
            mwdata_d = '0;
            mbe_d    = '1;
            starve_d = '0;
          end
          gnt_d: begin
            own_d    = OWN_D;
            mwe_d    = bus.d_we;
            maddr_d  = bus.d_addr;
            mwdata_d = bus.d_wdata;
            mbe_d    = bus.d_be;
            if (bus.if_req && starve_q != SMAX)
              starve_d = starve_q + 4'd1;
          end
          default: ;
        endcase
        if (gnt_i | gnt_d) begin
          mreq_d  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_ready) begin
          fin = 1'b1;
          cap = mwe_q ? '0 : bus.mem_rdata;
        end else if (tmo_exp) begin
          // Aborted access returns zero data.
          fin    = 1'b1;
          berr_d = 1'b1;
        end
        if (fin) begin
          mreq_d  = 1'b0;
          state_d = S_RESP;
          iack_d  = (own_q == OWN_I);
          dack_d  = (own_q == OWN_D);
          if (own_q == OWN_D) drdata_d = cap;
          else                irdata_d = cap;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.if_rdata  = irdata_q;
  assign bus.if_ack    = iack_q;
  assign bus.if_stall  = bus.if_req & ~iack_q;
  assign bus.d_rdata   = drdata_q;
  assign bus.d_ack     = dack_q;
  assign bus.d_stall   = bus.d_req & ~dack_q;
  assign bus.mem_req   = mreq_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_be    = mbe_q;
  assign bus.bus_err   = berr_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter.
// Table-driven transactions plus arbitration/timeout/reset sequences.
module tb_unified_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mrdata;
    int          waits;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    int          exp_stall;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic stall_of(bit is_d);
    return is_d ? bus.d_stall : bus.if_stall;
  endfunction

  function automatic logic ack_of(bit is_d);
    return is_d ? bus.d_ack : bus.if_ack;
  endfunction

  function automatic logic [31:0] rd_of(bit is_d);
    return is_d ? bus.d_rdata : bus.if_rdata;
  endfunction

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (bus.mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input vec_t v, input string t);
    bit bad;
    int sn;
    bad = 1'b0;
    sn  = 0;
    if (v.is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_be    = v.be;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    #1;
    if (stall_of(v.is_d)) sn++;
    step;
    chk({t, "_addr"}, bus.mem_addr, v.addr);
    chk({t, "_be"}, 32'(bus.mem_be), 32'(v.exp_be));
    chk({t, "_we"}, 32'(bus.mem_we), 32'(v.we));
    for (int w = 0; w <= v.waits; w++) begin
      if (!bus.mem_req || bus.mem_addr !== v.addr ||
          bus.mem_be !== v.exp_be || bus.mem_we !== v.we ||
          (v.we && bus.mem_wdata !== v.wdata))
        bad = 1'b1;
      if (stall_of(v.is_d)) sn++;
      bus.mem_ready = (w == v.waits);
      bus.mem_rdata = (w == v.waits) ? v.mrdata
                                     : 32'hDEAD0000 + 32'(w);
      step;
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    chk({t, "_stable"}, 32'(bad), 32'd0);
    chk({t, "_stallcyc"}, 32'(sn), 32'(v.exp_stall));
    chk({t, "_ack"}, 32'(ack_of(v.is_d)), 32'd1);
    chk({t, "_oack"}, 32'(ack_of(!v.is_d)), 32'd0);
    chk({t, "_rdata"}, rd_of(v.is_d), v.exp_rdata);
    chk({t, "_ordata"}, rd_of(!v.is_d), 32'd0);
    chk({t, "_mreq"}, 32'(bus.mem_req), 32'd0);
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    step;
    chk({t, "_ack1cyc"}, 32'(ack_of(v.is_d)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    bit pat [6];
    logic [31:0] da;
    logic [31:0] ia;
    vec_t v;

    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 4'h0,
                32'h00500093, 0, 32'h00500093, 4'hF, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h300, 32'h0, 4'hF,
                32'h12345678, 0, 32'h12345678, 4'hF, 2};
    vecs[2] = '{1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 4'hC,
                32'hFFFFFFFF, 1, 32'h0, 4'hC, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0, 4'h1,
                32'hA5A5A5A5, 3, 32'hA5A5A5A5, 4'h1, 5};
    vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0, 4'h0,
                32'h00000013, 2, 32'h00000013, 4'hF, 4};

    rst_n         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mreq", 32'(bus.mem_req), 32'd0);
    chk("rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
    chk("rst_berr", 32'(bus.bus_err), 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // mem_ready while idle must be ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h77;
    step;
    bus.mem_ready = 1'b0;
    chk("idle_rdy_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
    chk("idle_rdy_mreq", 32'(bus.mem_req), 32'd0);
    chk("idle_rdy_rd", bus.if_rdata | bus.d_rdata, 32'd0);

    // simultaneous requests: data first
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h108;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'h3;
    step;
    chk("sim_addr", bus.mem_addr, 32'h200);
    chk("sim_we", 32'(bus.mem_we), 32'd1);
    chk("sim_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sim_be", 32'(bus.mem_be), 32'h3);
    chk("sim_stalls", 32'({bus.if_stall, bus.d_stall}), 32'h3);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h11111111;
    step;
    bus.mem_ready = 1'b0;
    chk("sim_dack", 32'(bus.d_ack), 32'd1);
    chk("sim_drdata", bus.d_rdata, 32'd0);
    chk("sim_iack", 32'(bus.if_ack), 32'd0);
    chk("sim_irdata", bus.if_rdata, 32'd0);
    bus.d_req = 1'b0;
    step;
    step;
    chk("sim_i_addr", bus.mem_addr, 32'h108);
    chk("sim_i_we", 32'(bus.mem_we), 32'd0);
    chk("sim_i_be", 32'(bus.mem_be), 32'hF);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h22222222;
    step;
    bus.mem_ready = 1'b0;
    chk("sim_i_ack", 32'(bus.if_ack), 32'd1);
    chk("sim_i_rd", bus.if_rdata, 32'h22222222);
    bus.if_req = 1'b0;
    step;

    // starvation: 4 data grants, then fetch, then data
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    da = 32'h1000;
    ia = 32'h500;
    bus.if_req  = 1'b1;
    bus.if_addr = ia;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = da;
    bus.d_be    = 4'hF;
    for (int k = 0; k < 6; k++) begin
      wait_mem_req(ok);
      chk($sformatf("stv_wait%0d", k), 32'(ok), 32'd1);
      chk($sformatf("stv_addr%0d", k), bus.mem_addr,
          pat[k] ? da : ia);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'(k);
      step;
      bus.mem_ready = 1'b0;
      chk($sformatf("stv_dack%0d", k), 32'(bus.d_ack),
          32'(pat[k]));
      chk($sformatf("stv_iack%0d", k), 32'(bus.if_ack),
          32'(!pat[k]));
      if (bus.d_ack) begin
        da = da + 32'd4;
        bus.d_addr = da;
      end
      if (bus.if_ack) begin
        ia = ia + 32'd4;
        bus.if_addr = ia;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step;

    // timeout: memory never answers
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h600;
    bus.d_be      = 4'hF;
    bus.mem_rdata = 32'hBAD0BAD0;
    step;
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      step;
    end
    chk("tmo_busy_cycles", 32'(n), 32'd16);
    chk("tmo_ack", 32'(bus.d_ack), 32'd1);
    chk("tmo_rdata", bus.d_rdata, 32'd0);
    chk("tmo_berr", 32'(bus.bus_err), 32'd1);
    bus.d_req     = 1'b0;
    bus.mem_rdata = '0;
    step;
    chk("tmo_berr_hold", 32'(bus.bus_err), 32'd1);
    run_txn(vecs[1], "post_tmo");
    chk("tmo_berr_sticky", 32'(bus.bus_err), 32'd1);

    // async reset in the middle of a transfer
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h700;
    step;
    chk("rstb_mreq_pre", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstb_mreq", 32'(bus.mem_req), 32'd0);
    chk("rstb_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
    chk("rstb_berr", 32'(bus.bus_err), 32'd0);
    chk("rstb_maddr", bus.mem_addr, 32'd0);
    bus.if_req = 1'b0;
    #1;
    rst_n = 1'b1;
    step;
    v = '{1'b0, 1'b0, 32'h800, 32'h0, 4'h0,
          32'h00000033, 0, 32'h00000033, 4'hF, 2};
    run_txn(v, "post_rst");
    chk("post_rst_berr", 32'(bus.bus_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
